shared_adder_arbiter: RTL and testbench

//  - Shares one registered WIDTH-bit adder among NREQ requesters using round-robin arbitration.
//  - Requesters use a valid/ready handshake; the consumer sees one response stream (valid/ready).
//  - Sits between the top-level pin decode (ui_in/uio_in operand sources) and uo_out.
//  - Sequences the sum datapath so that one adder serves several operand sources.

---
 rtl/shared_adder_arbiter_pkg.sv | 46 ++++
 rtl/shared_adder_arbiter_rr_arbiter.sv | 68 ++++++
 rtl/shared_adder_arbiter.sv | 118 +++++++++++
 tb/tb_shared_adder_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_adder_arbiter_pkg.sv
// Shared definitions for the shared adder arbiter block.
//
// Contents:
//   sa_state_t  - output register state: IDLE (empty) or HOLD (result waiting)
//   NREQ_DEF    - default number of requesters
//   WIDTH_DEF   - default operand / sum width
//   MAX_REQ     - largest requester count the round-robin helper supports
//   rr_pick     - round-robin search returning a one-hot grant

package shared_adder_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } sa_state_t;

    localparam int NREQ_DEF  = 2;
    localparam int WIDTH_DEF = 8;
    localparam int MAX_REQ   = 8;

    // Returns a one-hot grant for the first set bit of valid, starting at
    // index ptr and wrapping at n. The result is zero when nothing is valid.
    // Only the low n bits of valid are examined.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [2:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if ((k < n) && !found) begin
                idx = 3'((int'(ptr) + k) % n);
                if (valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous reset, active low; pointer returns to 0
//   req_valid  - per-requester request lines
//   advance    - the current grant was taken; move the pointer past it
//   grant      - one-hot grant, zero when no request is valid
//   grant_idx  - binary index of the granted requester (0 when no grant)

module rr_arbiter
    import shared_adder_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         ptr_ext;
    logic [MAX_REQ-1:0] pick;

    // The package helper works on a fixed MAX_REQ-wide vector, so the
    // request lines and pointer are zero-extended before the search.
    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = req_valid;
        ptr_ext               = '0;
        ptr_ext[IDW-1:0]      = ptr_q;
        pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
        grant                 = pick[NREQ-1:0];
        grant_idx             = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick[i]) begin
                grant_idx = IDW'(i);
            end
        end
    end

    // After an accept, the requester just served drops to lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (grant_idx == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IDW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// One registered adder shared round-robin between NREQ requesters.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous reset, active low
//   req_valid  - per-requester operand valid
//   req_ready  - per-requester accept, one-hot or zero
//   req_a      - operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      - operand B, same packing as req_a
//   rsp_valid  - output register holds a result
//   rsp_ready  - consumer takes the result
//   rsp_sum    - (a+b) mod 2^WIDTH
//   rsp_carry  - carry-out of a+b
//   rsp_id     - index of the requester that produced the result

module shared_adder_arbiter
    import shared_adder_pkg::*;
#(
    parameter int  NREQ  = NREQ_DEF,
    parameter int  WIDTH = WIDTH_DEF,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        rsp_id
);

    sa_state_t         state_q, state_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IDW-1:0]    id_q, id_d;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              can_accept;
    logic              accept;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH:0]    sum_full;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A new result may enter when the register is empty or is being drained
    // this same cycle, which gives one result per cycle under full load.
    always_comb begin
        can_accept = (state_q == IDLE) || rsp_ready;
        req_ready  = grant & {NREQ{can_accept}};
        accept     = |(req_valid & req_ready);
    end

    // Operand mux for the granted requester feeding the single adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
        sum_full = {1'b0, a_sel} + {1'b0, b_sel};
    end

    // Output register FSM. Draining without a replacement leaves the last
    // sum, carry and id visible; only rsp_valid drops.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        if (accept) begin
            state_d = HOLD;
            sum_d   = sum_full[WIDTH-1:0];
            carry_d = sum_full[WIDTH];
            id_d    = grant_idx;
        end else if ((state_q == HOLD) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench for shared_adder_arbiter (NREQ=2, WIDTH=8).
// Directed scenarios followed by a randomized run, all scored against a
// cycle-level reference model of the arbitration and output register.

module tb_shared_adder_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [0:0]            rsp_id;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the consumer should see, plus the
    // round-robin start position, held as plain integers.
    int m_valid;
    int m_sum;
    int m_carry;
    int m_id;
    int m_ptr;
    int m_acc;

    shared_adder_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResponse();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        checkOutput("rsp_sum",   32'(rsp_sum),   32'(m_sum));
        checkOutput("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        checkOutput("rsp_id",    32'(rsp_id),    32'(m_id));
    endtask

    task automatic modelReset();
        m_valid = 0;
        m_sum   = 0;
        m_carry = 0;
        m_id    = 0;
        m_ptr   = 0;
        m_acc   = -1;
    endtask

    // First valid requester from the model pointer upward, with wrap.
    function automatic int modelGrant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Drives one cycle of inputs from a negedge, scores req_ready before the
    // edge, advances the model at the edge and scores rsp_* at the next negedge.
    task automatic applyStimulus(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                                 input logic [7:0] a1, input logic [7:0] b1, input logic rdy);
        int         g;
        int         can;
        int         total;
        logic [1:0] expRdy;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        rsp_ready = rdy;
        #1;
        g      = modelGrant(v);
        can    = (m_valid == 0 || rdy) ? 1 : 0;
        expRdy = (can != 0 && g >= 0) ? (2'b01 << g) : 2'b00;
        checkOutput("req_ready", 32'(req_ready), 32'(expRdy));
        @(posedge clk);
        m_acc = -1;
        if (can != 0 && g >= 0) begin
            total   = (g == 0) ? int'(a0) + int'(b0) : int'(a1) + int'(b1);
            m_sum   = total % 256;
            m_carry = total / 256;
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % NREQ;
            m_acc   = g;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
        @(negedge clk);
        checkResponse();
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] pv;
        logic [7:0] pa [2];
        logic [7:0] pb [2];
        int         cnt;

        $display("[TB] starting shared_adder_arbiter bench");
        doReset();

        // Reset state with nothing requesting.
        #1;
        checkResponse();
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

        // Single requester 0, then a carry-producing pair.
        applyStimulus(2'b01, 8'd3, 8'd4, 8'd0, 8'd0, 1'b1);
        checkOutput("simple_sum", 32'(rsp_sum), 32'd7);
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        applyStimulus(2'b01, 8'd200, 8'd100, 8'd0, 8'd0, 1'b1);
        checkOutput("carry_sum", 32'(rsp_sum), 32'd44);
        checkOutput("carry_bit", 32'(rsp_carry), 32'd1);
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

        // Alternation from reset: ids 0,1,0,1.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 8'(i), 8'd10, 8'(i + 20), 8'd30, 1'b1);
            checkOutput("alt_id", 32'(rsp_id), 32'(i % 2));
        end
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

        // Backpressure: result held for 5 cycles, then replaced in one cycle.
        applyStimulus(2'b01, 8'd50, 8'd60, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 8'd50, 8'd60, 8'd70, 8'd80, 1'b0);
            checkOutput("bp_hold_sum", 32'(rsp_sum), 32'd110);
        end
        applyStimulus(2'b11, 8'd50, 8'd60, 8'd70, 8'd80, 1'b1);
        checkOutput("bp_next_sum", 32'(rsp_sum), 32'd150);
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

        // Throughput: 8 results in 8 cycles.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b11, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            if (rsp_valid) cnt++;
        end
        checkOutput("thru_count", 32'(cnt), 32'd8);
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

        // Reset while holding a result from requester 1.
        doReset();
        applyStimulus(2'b10, 8'd0, 8'd0, 8'd9, 8'd9, 1'b0);
        applyStimulus(2'b10, 8'd0, 8'd0, 8'd9, 8'd9, 1'b0);
        checkOutput("pre_rst_id", 32'(rsp_id), 32'd1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResponse();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b11, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        checkOutput("post_rst_id", 32'(rsp_id), 32'd0);
        applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

        // Randomized traffic: requesters hold valid and operands until served.
        pv = '0;
        for (int i = 0; i < 2; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    pb[i] = 8'($urandom);
                end
            end
            applyStimulus(pv, pa[0], pb[0], pa[1], pb[1], ($urandom_range(0, 3) != 0));
            if (m_acc >= 0) pv[m_acc] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
